adder_txn_initiator: RTL

Hardware initiator for the adder interface (clk, reset, valid, a, b, c). It generates pseudo-random operand pairs, drives a/b/valid into the adder, waits the adder's fixed latency, and samples c. It checks each c against the internally computed a+b and reports a pass/fail summary. It is used for on-chip self-test and as a synthesizable stimulus source alongside the class-based bench.

---
 rtl/adder_txn_initiator_if.sv | 12 +
 rtl/adder_txn_initiator.sv | 110 +++++++++++
 2 files changed

// File: rtl/adder_txn_initiator_if.sv
// Adder bus: operands and valid from the initiator, result back from the adder.
interface adder_txn_initiator_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             valid;
  logic [WIDTH:0]   c;

  modport master (output a, output b, output valid, input c);
  modport slave  (input a, input b, input valid, output c);
endinterface

// File: rtl/adder_txn_initiator.sv
// Self-test initiator: drives LFSR operand pairs into an adder, waits its latency,
// and counts results that differ from the locally computed sum.
module adder_txn_initiator #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_TXN = 16,
  parameter int unsigned LATENCY = 1,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned CW      = $clog2(NUM_TXN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  adder_txn_initiator_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CW-1:0]         err_count,
  output logic [CW-1:0]         txn_count
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int unsigned LW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [LW-1:0] WAIT_LOAD = LW'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [CW-1:0] LAST_TXN  = CW'(NUM_TXN - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t           state, state_next;
  logic [15:0]      lfsr, lfsr_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   expected;
  logic [LW-1:0]    wait_cnt;
  logic             match;

  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign match     = (bus.c == expected);

  assign bus.a     = a_q;
  assign bus.b     = b_q;
  assign bus.valid = (state == S_ISSUE);
  assign busy      = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_ISSUE;
      S_ISSUE:        state_next = (LATENCY > 1) ? S_WAIT : S_CHECK;
      S_WAIT:         if (wait_cnt == '0) state_next = S_CHECK;
      S_CHECK:        state_next = (txn_count == LAST_TXN) ? S_DONE : S_ISSUE;
      default:        state_next = S_IDLE;
    endcase
    if (stop) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr      <= SEED_EFF;
      a_q       <= '0;
      b_q       <= '0;
      expected  <= '0;
      wait_cnt  <= '0;
      pass      <= 1'b0;
      err_count <= '0;
      txn_count <= '0;
    end else if (stop) begin
      pass <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            lfsr      <= SEED_EFF;
            a_q       <= SEED_EFF[WIDTH-1:0];
            b_q       <= SEED_EFF[2*WIDTH-1:WIDTH];
            pass      <= 1'b0;
            err_count <= '0;
            txn_count <= '0;
          end
        end
        S_ISSUE: begin
          expected <= {1'b0, a_q} + {1'b0, b_q};
          lfsr     <= lfsr_next;
          wait_cnt <= WAIT_LOAD;
        end
        S_WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
        end
        S_CHECK: begin
          if (!match) err_count <= err_count + 1'b1;
          txn_count <= txn_count + 1'b1;
          // pass must include the transaction being checked on this same edge
          if (txn_count == LAST_TXN) begin
            pass <= (err_count == '0) && match;
          end else begin
            a_q <= lfsr[WIDTH-1:0];
            b_q <= lfsr[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
